bp_be_fe_queue_buffer: RTL and testbench
========================================

Name: bp_be_fe_queue_buffer

Overview:
- Backend-side buffer that absorbs the FE fetch packet stream and presents packets in order to the issue/decode stage.
- Keeps three pointers: write, speculative read and commit. Issued-but-uncommitted packets can be replayed (roll) after a backend stall or redirect, or dropped (clr) on a flush.
- Sits directly downstream of the FE top, consuming fe_queue_o/fe_queue_v_o and driving fe_queue_ready_and_i.

Parameters:
- els_p, 8, entry count; power of two, >= 2.
- width_p, 128, fe_queue packet width (fe_queue_width_lp at instantiation).
- ptr_width_lp, $clog2(els_p)+1, local; pointer width including the wrap bit.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- fe_queue_i  in  width_p  packet from the FE.
- fe_queue_v_i  in  1  packet valid.
- fe_queue_ready_and_o  out  1  buffer can accept; enqueue occurs when v_i & ready_and_o.
- fe_queue_o  out  width_p  packet at the speculative read pointer.
- fe_queue_v_o  out  1  an unread packet is available.
- read_i  in  1  consumer takes fe_queue_o; advances the read pointer.
- cmt_i  in  1  retire the oldest issued packet; advances the commit pointer.
- roll_i  in  1  rewind the read pointer to the commit pointer (replay).
- clr_i  in  1  flush: discard all entries.
- full_o  out  1  entries held (w - c) == els_p.
- empty_o  out  1  entries held == 0.
- count_o  out  ptr_width_lp  w - c, number of resident entries.

Behaviour:
- State: wptr_r, rptr_r, cptr_r, each ptr_width_lp wide. Storage: els_p x width_p flop array indexed by ptr[ptr_width_lp-2:0]; the MSB is the wrap bit.
- Reset: asynchronous, active while reset_n_i=0. All pointers go to 0. fe_queue_v_o=0, full_o=0, empty_o=1, count_o=0, fe_queue_ready_and_o=1. Storage is not reset, so fe_queue_o is X until the first write.
- Reset deasserting mid-stream: the first enqueue can occur on the first rising edge with reset_n_i=1.
- full = (wptr_r[msb] != cptr_r[msb]) & (wptr_r[low] == cptr_r[low]).
- fe_queue_ready_and_o = ~full, from registered state only. There is no same-cycle bypass of a commit into free space, and ready_and_o does not depend on clr_i.
- Enqueue: when v_i & ready_and_o, write mem[wptr_r] and increment wptr (modulo 2^ptr_width_lp).
- Issue side, combinational from flops: fe_queue_v_o = (rptr_r != wptr_r); fe_queue_o = mem[rptr_r]. A packet becomes visible the cycle after it is enqueued; there is no flow-through.
- Read: the read pointer increments when read_i & fe_queue_v_o. read_i while fe_queue_v_o=0 is ignored.
- Commit: the commit pointer increments when cmt_i & (cptr_r != rptr_r). cmt_i with no issued entry is illegal; the RTL asserts on it and ignores it.
- Roll: the next read pointer is the next commit pointer, i.e. it includes any commit in the same cycle. A read_i in the same cycle is ignored.
- Clear: clr_i sets the write and read pointers to the current commit pointer and the commit pointer stays unchanged. The buffer is then empty and holds no uncommitted entries.
  - A same-cycle enqueue, read or commit is discarded.
  - A handshake that completed in the clr cycle still counts as accepted from the FE's view; the packet is dropped.
- Priority: clr_i > roll_i > read_i. Enqueue and commit are independent of read and roll.
- Simultaneous enqueue + commit at full: enqueue is blocked (ready_and_o=0). Commit frees one slot for the next cycle.
- Simultaneous enqueue + read when empty: read is ignored (v_o=0). The packet appears next cycle.
- Wrap-around: pointers wrap naturally. count_o = wptr_r - cptr_r, modulo 2^ptr_width_lp, and never exceeds els_p.
- Invariant, asserted: the read pointer always lies between the commit pointer and the write pointer, in ring distance c..w.
- Throughput: one enqueue, one read and one commit per cycle, all sustained.

Test Plan:
- Reset then fill: hold reset_n_i=0 for 3 cycles, then enqueue packets 1..8 back-to-back with els_p=8.
  - ready_and_o falls the cycle after the 8th accept.
  - full_o=1, count_o=8.
  - fe_queue_o=1, with fe_queue_v_o=1 from cycle 2.
- Stream with wrap: enqueue 20 packets while read_i=1 and cmt_i=1 every cycle the prior cycle read.
  - Output order is 1..20 with no bubble after the first.
  - count_o never exceeds 2.
  - Pointers wrap twice.
- Roll replay: enqueue A,B,C,D; read A,B,C; commit A; assert roll_i.
  - Next cycle fe_queue_o=B; reading yields B,C,D.
  - count_o=3.
- Roll + cmt same cycle: after reading A,B,C with nothing committed, assert roll_i and cmt_i together.
  - Next fe_queue_o=B, count_o=3.
- Clear with simultaneous enqueue: 4 resident (2 committed-read excluded), clr_i with v_i=1 packet E.
  - Next cycle empty_o=1, fe_queue_v_o=0.
  - E is not present; the next enqueue F reads out as F.
- Async reset mid-operation: drop reset_n_i between clock edges with 5 entries resident.
  - Outputs go to reset values immediately, before the next edge.
  - After release, empty_o=1 and ready_and_o=1.

Source files
------------

// File: rtl/bp_be_fe_queue_buffer.sv
// FE packet buffer with write, speculative read and commit pointers; issued packets can be replayed or flushed.
// Packets are visible one cycle after enqueue. ready_and_o falls only on full, and it never depends on same-cycle commit or clr.
module bp_be_fe_queue_buffer #(
    parameter int els_p   = 8,
    parameter int width_p = 128,
    localparam int ptr_width_lp = $clog2(els_p) + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      fe_queue_i,
    input  logic                    fe_queue_v_i,
    output logic                    fe_queue_ready_and_o,
    output logic [width_p-1:0]      fe_queue_o,
    output logic                    fe_queue_v_o,
    input  logic                    read_i,
    input  logic                    cmt_i,
    input  logic                    roll_i,
    input  logic                    clr_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [ptr_width_lp-1:0] count_o
);

    localparam int msb_lp = ptr_width_lp - 1;
    localparam int lo_lp  = ptr_width_lp - 2;

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] cptr_q, cptr_d;
    logic [width_p-1:0]      mem_q [els_p];

    logic full, enq, read_fire, cmt_fire;

    // Same low bits with opposite wrap bits means the writer is a full lap ahead of commit.
    assign full      = (wptr_q[msb_lp] != cptr_q[msb_lp]) & (wptr_q[lo_lp:0] == cptr_q[lo_lp:0]);
    assign enq       = fe_queue_v_i & ~full;
    assign read_fire = read_i & fe_queue_v_o;
    assign cmt_fire  = cmt_i & (cptr_q != rptr_q);

    assign fe_queue_ready_and_o = ~full;
    assign fe_queue_v_o         = (rptr_q != wptr_q);
    assign fe_queue_o           = mem_q[rptr_q[lo_lp:0]];
    assign full_o               = full;
    assign count_o              = wptr_q - cptr_q;
    assign empty_o              = (wptr_q == cptr_q);

    always_comb begin
        wptr_d = wptr_q + ptr_width_lp'(enq);
        rptr_d = rptr_q;
        cptr_d = cptr_q + ptr_width_lp'(cmt_fire);
        if (clr_i) begin
            wptr_d = cptr_q;
            rptr_d = cptr_q;
            cptr_d = cptr_q;
        end else if (roll_i) begin
            rptr_d = cptr_d;
        end else if (read_fire) begin
            rptr_d = rptr_q + ptr_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Storage is deliberately left unreset; a packet accepted during clr is simply dropped.
    always_ff @(posedge clk_i) begin
        if (enq && !clr_i) begin
            mem_q[wptr_q[lo_lp:0]] <= fe_queue_i;
        end
    end

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(cmt_i && (cptr_q == rptr_q)));
            assert ((rptr_q - cptr_q) <= (wptr_q - cptr_q));
            assert ((wptr_q - cptr_q) <= ptr_width_lp'(els_p));
        end
    end

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Randomized and directed bench for bp_be_fe_queue_buffer, checked against a packet-list model and a read scoreboard.
module tb_bp_be_fe_queue_buffer;

    localparam int ELS = 8;
    localparam int W   = 128;
    localparam int PW  = $clog2(ELS) + 1;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [W-1:0]  fe_queue_i = '0;
    logic          fe_queue_v_i = 1'b0;
    logic          fe_queue_ready_and_o;
    logic [W-1:0]  fe_queue_o;
    logic          fe_queue_v_o;
    logic          read_i = 1'b0;
    logic          cmt_i = 1'b0;
    logic          roll_i = 1'b0;
    logic          clr_i = 1'b0;
    logic          full_o;
    logic          empty_o;
    logic [PW-1:0] count_o;

    bp_be_fe_queue_buffer #(.els_p(ELS), .width_p(W)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i),
        .fe_queue_ready_and_o(fe_queue_ready_and_o),
        .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o),
        .read_i(read_i), .cmt_i(cmt_i), .roll_i(roll_i), .clr_i(clr_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Model: resident packets from oldest uncommitted onward, plus how many of them have been issued.
    logic [W-1:0] ents[$];
    int           mrd = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_n_i && read_i && fe_queue_v_o && !roll_i && !clr_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read_unexpected: got %0h expected no read", fe_queue_o);
            end else begin
                chk("read_data", fe_queue_o, exp_q.pop_front());
            end
        end
    end

    // One clock cycle: drive at posedge+1, check at negedge, advance the model, return at next posedge+1.
    task automatic step(input bit v, input logic [W-1:0] p, input bit rd, input bit cm,
                        input bit rl, input bit cl);
        int n;
        bit vo, en, cf, rf;
        n  = ents.size();
        vo = (mrd < n);
        en = v && (n < ELS);
        cf = cm && (mrd > 0);
        rf = rd && vo && !rl && !cl;
        fe_queue_v_i = v;
        fe_queue_i   = p;
        read_i       = rd;
        cmt_i        = cf;
        roll_i       = rl;
        clr_i        = cl;
        if (rf) exp_q.push_back(ents[mrd]);
        @(negedge clk_i);
        chk("count", W'(count_o), W'(n));
        chk("full", W'(full_o), W'(n == ELS));
        chk("empty", W'(empty_o), W'(n == 0));
        chk("ready", W'(fe_queue_ready_and_o), W'(n < ELS));
        chk("v_o", W'(fe_queue_v_o), W'(vo));
        if (vo) chk("peek", fe_queue_o, ents[mrd]);
        if (cl) begin
            ents.delete();
            mrd = 0;
        end else begin
            if (en) ents.push_back(p);
            if (cf) begin
                void'(ents.pop_front());
                mrd--;
            end
            if (rl) mrd = 0;
            else if (rf) mrd++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * ELS && ents.size() > 0; i++) step(0, '0, 1, 1, 0, 0);
    endtask

    initial begin
        // Reset then fill
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_count", W'(count_o), '0);
        chk("rst_empty", W'(empty_o), W'(1));
        chk("rst_ready", W'(fe_queue_ready_and_o), W'(1));
        chk("rst_v_o", W'(fe_queue_v_o), '0);
        reset_n_i = 1'b1;
        for (int k = 1; k <= ELS; k++) step(1, W'(k), 0, 0, 0, 0);
        step(1, W'(99), 0, 0, 0, 0);
        chk("fill_full", W'(full_o), W'(1));
        chk("fill_count", W'(count_o), W'(ELS));
        chk("fill_head", fe_queue_o, W'(1));
        step(0, '0, 0, 0, 0, 1);
        idle();

        // Stream with wrap
        for (int k = 1; k <= 20; k++) begin
            step(1, W'(k), 1, 1, 0, 0);
            chk("stream_count_le2", W'(count_o <= 2), W'(1));
        end
        drain();

        // Roll replay
        for (int k = 0; k < 4; k++) step(1, W'(32'hA0 + k), 0, 0, 0, 0);
        repeat (3) step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 1, 0, 1, 0);
        chk("roll_head", fe_queue_o, W'(32'hA1));
        chk("roll_count", W'(count_o), W'(3));
        repeat (3) step(0, '0, 1, 0, 0, 0);
        drain();

        // Roll with same-cycle commit
        for (int k = 0; k < 4; k++) step(1, W'(32'hB0 + k), 0, 0, 0, 0);
        repeat (3) step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        chk("rollcmt_head", fe_queue_o, W'(32'hB1));
        chk("rollcmt_count", W'(count_o), W'(3));
        drain();

        // Clear with simultaneous enqueue
        for (int k = 0; k < 6; k++) step(1, W'(32'hC0 + k), 0, 0, 0, 0);
        repeat (2) step(0, '0, 1, 1, 0, 0);
        step(0, '0, 1, 1, 0, 0);
        step(1, W'(32'hEE), 1, 0, 0, 1);
        chk("clr_empty", W'(empty_o), W'(1));
        chk("clr_v_o", W'(fe_queue_v_o), '0);
        step(1, W'(32'hFF), 0, 0, 0, 0);
        chk("clr_next", fe_queue_o, W'(32'hFF));
        step(0, '0, 1, 1, 0, 0);
        drain();

        // Randomized mix
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
        end
        drain();

        // Async reset mid-operation
        for (int k = 0; k < 5; k++) step(1, W'(32'hD0 + k), 0, 0, 0, 0);
        idle();
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_count", W'(count_o), '0);
        chk("arst_empty", W'(empty_o), W'(1));
        chk("arst_full", W'(full_o), '0);
        chk("arst_ready", W'(fe_queue_ready_and_o), W'(1));
        chk("arst_v_o", W'(fe_queue_v_o), '0);
        ents.delete();
        mrd = 0;
        exp_q.delete();
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        step(1, W'(32'h77), 0, 0, 0, 0);
        chk("post_rst_head", fe_queue_o, W'(32'h77));
        step(0, '0, 1, 1, 0, 0);
        drain();
        idle();

        chk("scoreboard_empty", W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
